stopwatch_display_feeder: RTL and testbench
===========================================

STOPWATCH_DISPLAY_FEEDER -- requirements
Module: stopwatch_display_feeder

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 500_000, meaning clk cycles per count increment (10 ms at 50 MHz).
REQ-002 SHALL have parameter MAX_COUNT, default 999_999, meaning the largest count value before wrap to 0.
REQ-003 SHALL have parameter DONE_TIMEOUT, default 1023, meaning clk cycles to wait for done before abandoning a write.
REQ-004 SHALL use one clock and an asynchronous active-low reset.
REQ-005 SHALL have port clk, input, 1, system clock.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port start_stop, input, 1, single-cycle pulse that toggles the run state.
REQ-008 SHALL have port clear, input, 1, single-cycle pulse that stops the stopwatch and zeroes the count.
REQ-009 SHALL have port rdy, input, 1, high when the downstream display stage accepts wen.
REQ-010 SHALL have port done, input, 1, single-cycle pulse from the display stage when the write is complete.
REQ-011 SHALL have port data, output, 32, binary count value offered to the display stage.
REQ-012 SHALL have port wen, output, 1, single-cycle write strobe.
REQ-013 SHALL have port base, output, 1, constant 1, selecting decimal display.
REQ-014 SHALL have port running, output, 1, high while counting.

Function
REQ-015 Prescaler SHALL count 0..TICK_CYCLES-1 while running=1, emit an internal tick on reaching TICK_CYCLES-1, then wrap to 0; it SHALL hold its value while running=0.
REQ-016 On a tick, count SHALL increment by 1; at MAX_COUNT it SHALL wrap to 0 on the same tick.
REQ-017 start_stop SHALL toggle running on the next clk edge and SHALL NOT reset the prescaler.
REQ-018 clear SHALL set running=0, count=0 and prescaler=0 on the next clk edge; if start_stop arrives in the same cycle, clear SHALL win.
REQ-019 Any count change, and any clear, SHALL set the sticky flag pend.
REQ-020 Write FSM SHALL have states S_IDLE, S_REQ and S_WAIT.
REQ-021 S_IDLE: if pend=1 and rdy=1, it SHALL latch count into data, clear pend and go to S_REQ; otherwise it SHALL stay in S_IDLE.
REQ-022 S_REQ: wen SHALL be 1 for exactly this one cycle; the FSM SHALL go to S_WAIT.
REQ-023 S_WAIT: on done=1 the FSM SHALL go to S_IDLE; if done has not arrived after DONE_TIMEOUT cycles, it SHALL set pend=1 and go to S_IDLE.
REQ-024 data SHALL remain stable from the S_REQ cycle until the FSM is back in S_IDLE.
REQ-025 A count change during S_REQ or S_WAIT SHALL set pend, so the write is issued after return to S_IDLE; intermediate values MAY be skipped, but the last value SHALL always be written.
REQ-026 If pend is set and cleared in the same cycle (latch coinciding with a tick), set SHALL win.
REQ-027 wen SHALL never be asserted in consecutive cycles.
REQ-028 done received outside S_WAIT SHALL be ignored.

Reset
REQ-029 While rst_n=0, outputs SHALL be: running=0, wen=0, data=0, base=1.
REQ-030 While rst_n=0, internal state SHALL be: count=0, prescaler=0, FSM=S_IDLE, pend=1 (so 0 is displayed after reset).
REQ-031 Reset asserted mid-write SHALL abort immediately with no further wen; the first write after release SHALL carry 0.

Verification
REQ-032 Release reset with rdy=1 and done returned 3 cycles after wen -> one wen pulse with data=0, then no further wen while idle.
REQ-033 TICK_CYCLES=4; pulse start_stop, run 40 cycles -> count=10; each wen data value is strictly increasing and ends at 10; running=1.
REQ-034 MAX_COUNT=5, TICK_CYCLES=2; run through wrap -> count sequence 4,5,0,1; a write with data=0 occurs after the wrap.
REQ-035 Hold rdy=0 for 100 cycles while counting -> no wen; raise rdy -> exactly one wen, carrying the current count.
REQ-036 Never return done -> wen, then DONE_TIMEOUT+1 cycles later wen again with the same data.
REQ-037 start_stop and clear in the same cycle while running -> running=0, count=0, then one wen with data=0.

Source files
------------

// File: rtl/stopwatch_display_feeder.sv
// -----------------------------------------------------------------------------
// stopwatch_display_feeder
//
// Purpose:
//   A centisecond-style stopwatch. A prescaler turns clk into count ticks. The
//   running count is pushed to a downstream display stage through a small
//   rdy/wen/done handshake. Writes are driven by a sticky "pending" flag, so
//   intermediate values may be skipped when the display is slow, but the most
//   recent count always ends up on the display.
//
// Parameters:
//   TICK_CYCLES  - clk cycles per count increment
//   MAX_COUNT    - largest count value; the next tick wraps to 0
//   DONE_TIMEOUT - cycles after wen to wait for done before retrying
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   start_stop in   single-cycle pulse, toggles running
//   clear      in   single-cycle pulse, stops and zeroes (wins over start_stop)
//   rdy        in   display stage can accept a write
//   done       in   single-cycle pulse, display write complete
//   data       out  [31:0] count value offered to the display
//   wen        out  single-cycle write strobe
//   base       out  constant 1 (decimal display)
//   running    out  high while counting
// -----------------------------------------------------------------------------
module stopwatch_display_feeder #(
  parameter int TICK_CYCLES  = 500_000,
  parameter int MAX_COUNT    = 999_999,
  parameter int DONE_TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        rdy,
  input  logic        done,
  output logic [31:0] data,
  output logic        wen,
  output logic        base,
  output logic        running
);

  localparam int PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int TMO_W = $clog2(DONE_TIMEOUT + 1);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYCLES - 1);
  localparam logic [31:0]      CNT_MAX  = 32'(MAX_COUNT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DONE_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  logic             r_running;
  logic [PRE_W-1:0] r_presc;
  logic [31:0]      r_count;
  logic             r_pend;
  state_t           r_state;
  logic [31:0]      r_data;
  logic             r_wen;
  logic [TMO_W-1:0] r_tmo;

  logic w_tick;
  logic w_latch;
  logic w_timeout;
  logic w_pend_set;

  assign w_tick     = r_running && (r_presc == PRE_LAST);
  assign w_latch    = (r_state == S_IDLE) && r_pend && rdy;
  // r_tmo counts cycles since the wen cycle, so a retry strobe lands
  // DONE_TIMEOUT+1 cycles after the abandoned one.
  assign w_timeout  = (r_state == S_WAIT) && !done && (r_tmo >= TMO_LAST);
  assign w_pend_set = w_tick || clear || w_timeout;

  // Run state, prescaler and count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_running <= 1'b0;
      r_presc   <= '0;
      r_count   <= '0;
    end else if (clear) begin
      r_running <= 1'b0;
      r_presc   <= '0;
      r_count   <= '0;
    end else begin
      if (start_stop) r_running <= ~r_running;
      // start_stop deliberately leaves the prescaler phase untouched
      if (r_running) r_presc <= w_tick ? '0 : r_presc + PRE_W'(1);
      if (w_tick)    r_count <= (r_count == CNT_MAX) ? '0 : r_count + 32'd1;
    end
  end

  // Sticky pending flag; a new request beats the latch that would clear it.
  // Reset value 1 forces a write of 0 right after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_pend <= 1'b1;
    else if (w_pend_set) r_pend <= 1'b1;
    else if (w_latch)    r_pend <= 1'b0;
  end

  // Write FSM; data is only reloaded in S_IDLE so it holds through the write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_data  <= '0;
      r_wen   <= 1'b0;
      r_tmo   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_wen <= 1'b0;
          if (w_latch) begin
            r_data  <= r_count;
            r_wen   <= 1'b1;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          r_wen   <= 1'b0;
          r_tmo   <= TMO_W'(1);
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_wen <= 1'b0;
          if (done || w_timeout) r_state <= S_IDLE;
          else                   r_tmo   <= r_tmo + TMO_W'(1);
        end
        default: begin
          r_wen   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign data    = r_data;
  assign wen     = r_wen;
  assign base    = 1'b1;
  assign running = r_running;

endmodule

// File: tb/tb_stopwatch_display_feeder.sv
module tb_stopwatch_display_feeder;

  localparam int A_TMO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Instance A: TICK_CYCLES=4, default wrap point
  logic        a_ss, a_clr, a_rdy;
  logic        a_done = 1'b0;
  logic [31:0] a_data;
  logic        a_wen, a_base, a_running;

  // Instance B: TICK_CYCLES=2, MAX_COUNT=5 for the wrap scenario
  logic        b_ss, b_clr, b_rdy;
  logic        b_done = 1'b0;
  logic [31:0] b_data;
  logic        b_wen, b_base, b_running;

  stopwatch_display_feeder #(
    .TICK_CYCLES(4), .MAX_COUNT(999_999), .DONE_TIMEOUT(A_TMO)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .start_stop(a_ss), .clear(a_clr),
    .rdy(a_rdy), .done(a_done), .data(a_data), .wen(a_wen),
    .base(a_base), .running(a_running)
  );

  stopwatch_display_feeder #(
    .TICK_CYCLES(2), .MAX_COUNT(5), .DONE_TIMEOUT(A_TMO)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start_stop(b_ss), .clear(b_clr),
    .rdy(b_rdy), .done(b_done), .data(b_data), .wen(b_wen),
    .base(b_base), .running(b_running)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor and done responder for A (done follows wen by a_dly cycles; 0 = never)
  int          a_cyc = 0, a_wens = 0, a_zero_wens = 0, a_consec = 0;
  int          a_t_last = 0, a_t_prev = 0;
  int          a_dly = 3, a_dcnt = 0;
  logic [31:0] a_last = 0, a_d_prev = 0;
  logic        a_mono = 1'b1, a_wen_q = 1'b0;

  always @(negedge clk) begin
    a_cyc++;
    a_done = 1'b0;
    if (a_wen === 1'b1) begin
      if (a_wen_q) a_consec++;
      if (a_wens > 0 && a_data <= a_last) a_mono = 1'b0;
      a_d_prev = a_last;
      a_t_prev = a_t_last;
      a_last   = a_data;
      a_t_last = a_cyc;
      a_wens++;
      if (a_data == 0) a_zero_wens++;
      a_dcnt = a_dly;
    end else if (a_dcnt > 0) begin
      a_dcnt--;
      if (a_dcnt == 0) a_done = 1'b1;
    end
    a_wen_q = (a_wen === 1'b1);
  end

  // Monitor and done responder for B; also logs every count change
  int          b_seq[$];
  logic [31:0] b_prev_cnt = 0, b_last = 0;
  logic        b_wrap = 1'b0, b_zero_after_wrap = 1'b0;
  int          b_dcnt = 0;

  always @(negedge clk) begin
    b_done = 1'b0;
    if (rst_n === 1'b1 && dut_b.r_count != b_prev_cnt) begin
      b_seq.push_back(int'(dut_b.r_count));
      if (b_prev_cnt == 5 && dut_b.r_count == 0) b_wrap = 1'b1;
      b_prev_cnt = dut_b.r_count;
    end
    if (b_wen === 1'b1) begin
      b_last = b_data;
      if (b_wrap && b_data == 0) b_zero_after_wrap = 1'b1;
      b_dcnt = 1;
    end else if (b_dcnt > 0) begin
      b_dcnt--;
      if (b_dcnt == 0) b_done = 1'b1;
    end
  end

  function automatic int seq_at(input int i);
    return (i < b_seq.size()) ? b_seq[i] : -1;
  endfunction

  initial begin
    int  n0;
    int  z0;
    logic found;

    rst_n = 1'b0;
    a_ss = 0; a_clr = 0; a_rdy = 1;
    b_ss = 0; b_clr = 0; b_rdy = 1;
    step(3);

    // Reset state
    check("rst_wen",     32'(a_wen),     0);
    check("rst_data",    a_data,         0);
    check("rst_running", 32'(a_running), 0);
    check("rst_base",    32'(a_base),    1);
    check("rst_count",   dut_a.r_count,  0);

    // Boot: exactly one write of 0, then quiet
    rst_n = 1'b1;
    step(20);
    check("boot_wens", 32'(a_wens), 1);
    check("boot_data", a_last,      0);

    // Count 40 cycles at TICK_CYCLES=4
    a_mono = 1'b1;
    a_ss = 1; step(1); a_ss = 0;
    step(40);
    check("run40_count",   dut_a.r_count,  10);
    check("run40_running", 32'(a_running), 1);
    a_ss = 1; step(1); a_ss = 0;
    step(20);
    check("run40_mono",    32'(a_mono),    1);
    check("run40_last",    a_last,         10);
    check("run40_stopped", 32'(a_running), 0);

    // rdy held low while counting: no writes, then one write of the final count
    a_clr = 1; step(1); a_clr = 0;
    step(10);
    a_rdy = 0;
    n0 = a_wens;
    a_ss = 1; step(1); a_ss = 0;
    step(97);
    a_ss = 1; step(1); a_ss = 0;
    step(2);
    check("rdy0_nowen",  32'(a_wens - n0), 0);
    check("rdy0_count",  dut_a.r_count,    24);
    a_rdy = 1;
    step(15);
    check("rdy1_onewen", 32'(a_wens - n0), 1);
    check("rdy1_data",   a_last,           24);

    // done never returned: retry after DONE_TIMEOUT+1 cycles with same data
    a_dly = 0;
    a_clr = 1; step(1); a_clr = 0;
    step(A_TMO + 8);
    check("tmo_gap",   32'(a_t_last - a_t_prev), A_TMO + 1);
    check("tmo_data1", a_d_prev, 0);
    check("tmo_data2", a_last,   0);
    a_dly = 3;
    step(20);

    // start_stop and clear together while running: clear wins
    a_ss = 1; step(1); a_ss = 0;
    step(10);
    check("ssclr_pre_running", 32'(a_running), 1);
    z0 = a_zero_wens;
    a_ss = 1; a_clr = 1; step(1); a_ss = 0; a_clr = 0;
    check("ssclr_running", 32'(a_running), 0);
    check("ssclr_count",   dut_a.r_count,  0);
    step(25);
    check("ssclr_zero_wens", 32'(a_zero_wens - z0), 1);
    check("ssclr_last",      a_last,                0);

    // Wrap at MAX_COUNT=5 on instance B
    b_ss = 1; step(1); b_ss = 0;
    step(11);
    b_ss = 1; step(1); b_ss = 0;
    step(12);
    check("wrap_count0",     dut_b.r_count,           0);
    check("wrap_zero_write", 32'(b_zero_after_wrap), 1);
    check("wrap_last",       b_last,                  0);
    b_ss = 1; step(1); b_ss = 0;
    step(3);
    b_ss = 1; step(1); b_ss = 0;
    step(10);
    check("wrap_seq3", 32'(seq_at(3)), 4);
    check("wrap_seq4", 32'(seq_at(4)), 5);
    check("wrap_seq5", 32'(seq_at(5)), 0);
    check("wrap_seq6", 32'(seq_at(6)), 1);

    // Reset asserted mid-write
    a_ss = 1; step(1); a_ss = 0;
    step(10);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (a_wen === 1'b1) found = 1'b1;
      else step(1);
    end
    check("midwr_found", 32'(found), 1);
    step(1);
    n0 = a_wens;
    rst_n = 1'b0;
    #1;
    check("midwr_rst_wen",     32'(a_wen),     0);
    check("midwr_rst_data",    a_data,         0);
    check("midwr_rst_running", 32'(a_running), 0);
    step(3);
    check("midwr_rst_nowen", 32'(a_wens - n0), 0);
    rst_n = 1'b1;
    step(20);
    check("midwr_post_wens", 32'(a_wens - n0), 1);
    check("midwr_post_data", a_last,           0);

    check("no_consec_wen", 32'(a_consec), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
